// File: rtl/exc_ctrl.sv
// exc_ctrl: exception detection, priority arbitration and pipeline-flush sequencing at MEM/WB.
// Optional macro EXC_CTRL_COUNT_EN adds a saturating taken-exception counter on exc_count_o.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_delayslot_i,
  input  logic        exc_syscall_i,
  input  logic        exc_inst_invalid_i,
  input  logic        exc_trap_i,
  input  logic        exc_ov_i,
  input  logic        exc_eret_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] exc_inst_addr_o,
  output logic        exc_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
`ifdef EXC_CTRL_COUNT_EN
  ,
  output logic [15:0] exc_count_o
`endif
);

  localparam int unsigned CNT_W = 4;
  localparam logic [4:0]  CP0_STATUS = 5'd12;
  localparam logic [4:0]  CP0_CAUSE  = 5'd13;
  localparam logic [4:0]  CP0_EPC    = 5'd14;

  localparam logic [31:0] EXC_NONE    = 32'h0;
  localparam logic [31:0] EXC_INT     = 32'h1;
  localparam logic [31:0] EXC_SYSCALL = 32'h8;
  localparam logic [31:0] EXC_INVALID = 32'ha;
  localparam logic [31:0] EXC_TRAP    = 32'hd;
  localparam logic [31:0] EXC_OV      = 32'hc;
  localparam logic [31:0] EXC_ERET    = 32'he;

  typedef enum logic {
    ST_IDLE,
    ST_FLUSH
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [31:0]        r_excepttype;
  logic [31:0]        w_excepttype_nxt;
  logic [31:0]        r_exc_addr;
  logic [31:0]        w_exc_addr_nxt;
  logic               r_exc_ds;
  logic               w_exc_ds_nxt;
  logic               r_flush;
  logic               w_flush_nxt;
  logic [31:0]        r_new_pc;
  logic [31:0]        w_new_pc_nxt;

  logic [31:0]        w_status_f;
  logic [31:0]        w_cause_f;
  logic [31:0]        w_epc_f;
  logic               w_int_pending;
  logic [31:0]        w_code;
  logic               w_unused;

  // Newest CP0 view: a WB-stage write overrides the CP0 register outputs
  always_comb begin
    w_status_f = cp0_status_i;
    w_cause_f  = cp0_cause_i;
    w_epc_f    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        CP0_STATUS: w_status_f = wb_cp0_data_i;
        CP0_CAUSE: begin
          // Only the software-writable cause fields are forwarded
          w_cause_f[9:8]   = wb_cp0_data_i[9:8];
          w_cause_f[23:22] = wb_cp0_data_i[23:22];
        end
        CP0_EPC:    w_epc_f = wb_cp0_data_i;
        default: ;
      endcase
    end
  end

  assign w_int_pending = (|(w_cause_f[15:8] & w_status_f[15:8])) &&
                         w_status_f[0] && !w_status_f[1];

  assign w_unused = ^{w_status_f[31:16], w_status_f[7:2], w_cause_f[31:16], w_cause_f[7:0]};

  // Fixed-priority exception encoder
  always_comb begin
    w_code = EXC_NONE;
    if (w_int_pending)           w_code = EXC_INT;
    else if (exc_syscall_i)      w_code = EXC_SYSCALL;
    else if (exc_inst_invalid_i) w_code = EXC_INVALID;
    else if (exc_trap_i)         w_code = EXC_TRAP;
    else if (exc_ov_i)           w_code = EXC_OV;
    else if (exc_eret_i)         w_code = EXC_ERET;
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_excepttype_nxt = EXC_NONE;
    w_exc_addr_nxt   = r_exc_addr;
    w_exc_ds_nxt     = r_exc_ds;
    w_flush_nxt      = 1'b0;
    w_new_pc_nxt     = 32'h0;
    case (r_state)
      ST_IDLE: begin
        if (inst_valid_i && (w_code != EXC_NONE)) begin
          w_state_nxt      = ST_FLUSH;
          w_cnt_nxt        = CNT_W'(FLUSH_CYCLES - 1);
          w_excepttype_nxt = w_code;
          w_exc_addr_nxt   = inst_addr_i;
          w_exc_ds_nxt     = in_delayslot_i;
          w_flush_nxt      = 1'b1;
          w_new_pc_nxt     = (w_code == EXC_ERET) ? w_epc_f : EXC_VECTOR;
        end
      end
      ST_FLUSH: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt    = r_cnt - CNT_W'(1);
          w_flush_nxt  = 1'b1;
          w_new_pc_nxt = r_new_pc;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_excepttype <= '0;
      r_exc_addr   <= '0;
      r_exc_ds     <= 1'b0;
      r_flush      <= 1'b0;
      r_new_pc     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_excepttype <= w_excepttype_nxt;
      r_exc_addr   <= w_exc_addr_nxt;
      r_exc_ds     <= w_exc_ds_nxt;
      r_flush      <= w_flush_nxt;
      r_new_pc     <= w_new_pc_nxt;
    end
  end

  assign excepttype_o    = r_excepttype;
  assign exc_inst_addr_o = r_exc_addr;
  assign exc_delayslot_o = r_exc_ds;
  assign flush_o         = r_flush;
  assign new_pc_o        = r_new_pc;

`ifdef EXC_CTRL_COUNT_EN
  logic [15:0] r_exc_count;

  // Counts reported exceptions (eret excluded), saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exc_count <= '0;
    end else if ((r_excepttype != EXC_NONE) && (r_excepttype != EXC_ERET) &&
                 (r_exc_count != 16'hFFFF)) begin
      r_exc_count <= r_exc_count + 16'd1;
    end
  end

  assign exc_count_o = r_exc_count;
`endif

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception detection, arbitration and flush-sequencing unit at the MEM/WB boundary.
- Consumes the CP0 status/cause/epc outputs and the per-instruction exception flags. Produces the excepttype / instruction-address / delay-slot triple that CP0 consumes.
- Drives the pipeline flush and the redirect PC: the exception vector, or EPC for eret.
- Forwards an in-flight CP0 write from WB so decisions always use the newest status, cause and EPC.

Parameters:
- EXC_VECTOR, 32'h00000020, redirect target for every exception except eret.
- FLUSH_CYCLES, 1, cycles flush_o stays asserted per taken event (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- inst_valid_i  in  1  MEM-stage slot holds a real instruction
- inst_addr_i  in  32  PC of MEM-stage instruction
- in_delayslot_i  in  1  MEM instruction is in a delay slot
- exc_syscall_i  in  1  syscall flag
- exc_inst_invalid_i  in  1  reserved/invalid instruction flag
- exc_trap_i  in  1  trap condition true
- exc_ov_i  in  1  arithmetic overflow
- exc_eret_i  in  1  eret instruction
- cp0_status_i  in  32  CP0 Status
- cp0_cause_i  in  32  CP0 Cause
- cp0_epc_i  in  32  CP0 EPC
- wb_cp0_we_i  in  1  WB-stage CP0 write enable
- wb_cp0_waddr_i  in  5  WB-stage CP0 write address
- wb_cp0_data_i  in  32  WB-stage CP0 write data
- excepttype_o  out  32  exception code to CP0 (one-cycle pulse)
- exc_inst_addr_o  out  32  faulting PC to CP0
- exc_delayslot_o  out  1  delay-slot flag to CP0
- flush_o  out  1  flush all pipeline registers
- new_pc_o  out  32  redirect target, valid while flush_o=1

Behaviour:
- Forwarding (combinational), applied when wb_cp0_we_i=1:
  - waddr=12: status_f = wb data.
  - waddr=13: cause_f = cp0_cause_i with bits [9:8], 23 and 22 taken from wb data.
  - waddr=14: epc_f = wb data.
  - Otherwise status_f, cause_f and epc_f equal the CP0 inputs.
- Interrupt pending: (cause_f[15:8] & status_f[15:8]) != 0, AND status_f[0]=1 (IE), AND status_f[1]=0 (EXL).
- Arbitration applies only when inst_valid_i=1 and the FSM is in IDLE. Priority, highest first:
  - interrupt 0x1
  - syscall 0x8
  - invalid 0xa
  - trap 0xd
  - overflow 0xc
  - eret 0xe
  - none 0x0
- FSM states:
  - IDLE: on a nonzero code in cycle N, register the outputs and move to FLUSH in cycle N+1.
  - FLUSH: a 4-bit counter loads FLUSH_CYCLES-1 on entry and decrements each cycle. Return to IDLE the cycle after the counter reads 0.
- Output timing for an event detected in cycle N:
  - excepttype_o = code, exc_inst_addr_o = inst_addr_i, exc_delayslot_o = in_delayslot_i, all in cycle N+1 only. excepttype_o returns to 0 in N+2 even if FLUSH continues. The addr and delayslot outputs hold their last value.
  - flush_o = 1 for cycles N+1 through N+FLUSH_CYCLES.
  - new_pc_o = epc_f (captured in cycle N) for eret, otherwise EXC_VECTOR. It holds during FLUSH and reads 0 in IDLE.
- While in FLUSH, all inputs are ignored, including interrupts. The first re-evaluation happens in the first IDLE cycle.
- Simultaneous flags: only the highest priority is reported; the lower ones are dropped. They are not queued.
- An interrupt with inst_valid_i=0 is not taken. It stays pending in CP0 and is taken on the next valid instruction.
- Reset values:
  - excepttype_o=0, exc_inst_addr_o=0, exc_delayslot_o=0, flush_o=0, new_pc_o=0, FSM=IDLE, counter=0.
- Reset mid-FLUSH: return to IDLE next cycle with all outputs zeroed and no further pulse.

Optional Feature:
- Macro EXC_CTRL_COUNT_EN.
- When defined: add output exc_count_o (16 bits), reset to 0.
  - It increments in the cycle excepttype_o holds any code other than 0x0 or 0xe.
  - It saturates at 16'hFFFF.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Interrupt taken: status=0x1000FF01, cause=0x00000400, valid, addr=0x100 -> N+1: excepttype_o=0x1, exc_inst_addr_o=0x100, flush_o=1, new_pc_o=0x20; N+2: excepttype_o=0, flush_o=0 (FLUSH_CYCLES=1).
- Priority: syscall=1, ov=1, eret=1, addr=0x200, in_delayslot=1 -> excepttype_o=0x8, exc_delayslot_o=1, new_pc_o=0x20; no 0xc or 0xe pulse follows.
- eret with forwarding: cp0_epc_i=0x40, WB writes EPC (addr 14) = 0x88 in the same cycle -> new_pc_o=0x88, excepttype_o=0xe.
- Interrupt masking: status=0x1000FF03 (EXL=1), cause IP set -> no event. Same cycle, WB writes status=0x1000FF01 -> interrupt taken (0x1).
- Flush masking: FLUSH_CYCLES=3, syscall at N, overflow at N+1..N+3 -> flush_o high N+1..N+3; overflow held to N+4 -> excepttype_o=0xc at N+5.
- Reset mid-flush and counter: rst at N+2 of a 3-cycle flush -> flush_o=0 at N+3. With EXC_CTRL_COUNT_EN, three syscalls plus one eret -> exc_count_o=3.
